// File: rtl/cv32e41p_pkg.sv
// Shared types and constants for the cv32e41p wake controller slice.
package cv32e41p_pkg;

    localparam int unsigned WAKE_DELAY_W = 4;

    typedef enum logic [1:0] {
        WK_RUN,
        WK_DRAIN,
        WK_SLEEP,
        WK_WAKE
    } wake_ctrl_state_e;

endpackage

// File: rtl/cv32e41p_sat_counter.sv
// Parameterised-width saturating up-counter; clear wins over increment.
module cv32e41p_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cv32e41p_wake_ctrl.sv
// WFI sleep-entry/wake-up sequencer on the ungated clock: drains units, lets the
// sleep unit gate the core clock, and retires the WFI after a settle delay on wake.
module cv32e41p_wake_ctrl
    import cv32e41p_pkg::*;
#(
    parameter int unsigned WAKE_DELAY = 2
) (
    input  logic        clk_ungated_i,
    input  logic        rst_i,
    input  logic        wfi_req_i,
    input  logic        debug_wfi_no_sleep_i,
    input  logic        if_busy_i,
    input  logic        lsu_busy_i,
    input  logic        apu_busy_i,
    input  logic [31:0] irq_i,
    input  logic [31:0] mie_i,
    input  logic        debug_req_i,
    output logic        wfi_ack_o,
    output logic        ctrl_busy_o,
    output logic        wake_from_sleep_o,
    input  logic        sleep_cnt_clr_i,
    output logic [31:0] sleep_cnt_o
);

    localparam logic [WAKE_DELAY_W-1:0] DelayMax = WAKE_DELAY[WAKE_DELAY_W-1:0];

    wake_ctrl_state_e        state_d, state_q;
    logic [WAKE_DELAY_W-1:0] dly_d, dly_q;
    logic                    wake_pend;
    logic                    units_idle;

    // Deliberately ignores the global MIE bit: a disabled-but-enabled-in-mie irq still wakes.
    assign wake_pend  = (|(irq_i & mie_i)) | debug_req_i;
    assign units_idle = !if_busy_i && !lsu_busy_i && !apu_busy_i;

    always_comb begin
        state_d           = state_q;
        dly_d             = dly_q;
        wfi_ack_o         = 1'b0;
        ctrl_busy_o       = 1'b1;
        wake_from_sleep_o = 1'b0;
        unique case (state_q)
            WK_RUN: begin
                if (wfi_req_i) begin
                    if (debug_wfi_no_sleep_i || wake_pend) begin
                        wfi_ack_o = 1'b1;
                    end else begin
                        state_d = WK_DRAIN;
                    end
                end
            end
            WK_DRAIN: begin
                if (wake_pend) begin
                    state_d = WK_WAKE;
                    dly_d   = '0;
                end else if (units_idle) begin
                    state_d = WK_SLEEP;
                end
            end
            WK_SLEEP: begin
                ctrl_busy_o = 1'b0;
                if (wake_pend) begin
                    wake_from_sleep_o = 1'b1;
                    state_d           = WK_WAKE;
                    dly_d             = '0;
                end
            end
            WK_WAKE: begin
                if (dly_q == DelayMax) begin
                    wfi_ack_o = 1'b1;
                    state_d   = WK_RUN;
                    dly_d     = '0;
                end else begin
                    dly_d = dly_q + WAKE_DELAY_W'(1);
                end
            end
            default: begin
                state_d = WK_RUN;
                dly_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_ungated_i) begin
        if (rst_i) begin
            state_q <= WK_RUN;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    cv32e41p_sat_counter #(
        .Width(32)
    ) u_sleep_cnt (
        .clk_i(clk_ungated_i),
        .rst_i(rst_i),
        .clr_i(sleep_cnt_clr_i),
        .inc_i(state_q == WK_SLEEP),
        .cnt_o(sleep_cnt_o)
    );

endmodule

// File: tb/tb_cv32e41p_wake_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a phase-level model.
module tb_cv32e41p_wake_ctrl;

    localparam int unsigned Delay = 2;
    localparam int PhRun = 0, PhDrain = 1, PhSleep = 2, PhWake = 3;

    logic        clk = 1'b0;
    logic        rst, wfi_req, nop, if_b, lsu_b, apu_b, dbg, clr;
    logic [31:0] irq, mie;
    logic        ack, busy, wfs;
    logic [31:0] cnt;
    logic        sc_clr, sc_inc;
    logic [2:0]  sc_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: which phase of the WFI sequence we are in, plus settle cycles left.
    int              m_ph = PhRun;
    int              m_left = 0;
    longint unsigned m_cnt = 0;
    logic            exp_ack, exp_busy, exp_wfs;
    logic [31:0]     exp_cnt;

    cv32e41p_wake_ctrl #(
        .WAKE_DELAY(Delay)
    ) dut (
        .clk_ungated_i(clk),
        .rst_i(rst),
        .wfi_req_i(wfi_req),
        .debug_wfi_no_sleep_i(nop),
        .if_busy_i(if_b),
        .lsu_busy_i(lsu_b),
        .apu_busy_i(apu_b),
        .irq_i(irq),
        .mie_i(mie),
        .debug_req_i(dbg),
        .wfi_ack_o(ack),
        .ctrl_busy_o(busy),
        .wake_from_sleep_o(wfs),
        .sleep_cnt_clr_i(clr),
        .sleep_cnt_o(cnt)
    );

    cv32e41p_sat_counter #(
        .Width(3)
    ) u_sat (
        .clk_i(clk),
        .rst_i(rst),
        .clr_i(sc_clr),
        .inc_i(sc_inc),
        .cnt_o(sc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic pend();
        return ((irq & mie) != 32'h0) || dbg;
    endfunction

    function automatic void model_eval();
        exp_ack  = (m_ph == PhRun && wfi_req && (nop || pend())) || (m_ph == PhWake && m_left == 1);
        exp_busy = (m_ph != PhSleep);
        exp_wfs  = (m_ph == PhSleep) && pend();
        exp_cnt  = m_cnt[31:0];
    endfunction

    function automatic void model_advance();
        if (rst) begin
            m_ph  = PhRun;
            m_cnt = 0;
            return;
        end
        if (clr) m_cnt = 0;
        else if (m_ph == PhSleep && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
        case (m_ph)
            PhRun:   if (wfi_req && !(nop || pend())) m_ph = PhDrain;
            PhDrain: begin
                if (pend()) begin
                    m_ph = PhWake; m_left = Delay + 1;
                end else if (!if_b && !lsu_b && !apu_b) begin
                    m_ph = PhSleep;
                end
            end
            PhSleep: if (pend()) begin
                m_ph = PhWake; m_left = Delay + 1;
            end
            default: begin
                m_left = m_left - 1;
                if (m_left == 0) m_ph = PhRun;
            end
        endcase
    endfunction

    task automatic settle();
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        wfi_req = 0; nop = 0; if_b = 0; lsu_b = 0; apu_b = 0; dbg = 0; clr = 0;
        irq = 32'h0; mie = 32'h0; sc_clr = 0; sc_inc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #1;
        tick();
        tick();
        rst = 0;
        settle();
        checks++;
        if ({ack, busy, wfs, cnt} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: ack/busy/wake/cnt got %b %b %b %h want 0 1 0 0", ack, busy, wfs, cnt);
        end
    endtask

    task automatic test_nop();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            wfi_req = (c == 0 || c == 2);
            nop     = (c == 0);
            irq     = (c == 2) ? 32'h0000_0080 : 32'h0;
            mie     = 32'h0000_0080;
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL nop c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs, cnt,
                         exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            checks++;
            if (ack !== (c == 0 || c == 2) || busy !== 1'b1 || cnt !== 32'h0) begin
                errors++;
                $display("FAIL nop_direct c%0d: ack %b busy %b cnt %h", c, ack, busy, cnt);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_full_sleep();
        do_reset();
        for (int c = 0; c < 15; c++) begin
            wfi_req = (c <= 13);
            lsu_b   = (c <= 2);
            irq     = (c == 10) ? 32'h0000_0800 : 32'h0;
            mie     = (c == 10) ? 32'h0000_0800 : 32'h0;
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL full_sleep c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs,
                         cnt, exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            if (c == 4 || c == 10 || c == 13) begin
                checks++;
                if ((c == 4 && busy !== 1'b0) || (c == 10 && (wfs !== 1'b1 || cnt !== 32'd6)) ||
                    (c == 13 && ack !== 1'b1)) begin
                    errors++;
                    $display("FAIL full_sleep_direct c%0d: busy %b wake %b cnt %0d ack %b", c, busy,
                             wfs, cnt, ack);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_abort_drain();
        longint unsigned start_cnt = m_cnt;
        for (int c = 0; c < 6; c++) begin
            wfi_req = (c <= 4);
            dbg     = (c == 1);
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL abort c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs, cnt,
                         exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            checks++;
            if (busy !== 1'b1 || cnt !== start_cnt[31:0] || ack !== (c == 4)) begin
                errors++;
                $display("FAIL abort_direct c%0d: busy %b cnt %h ack %b", c, busy, cnt, ack);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_masked_irq();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            wfi_req = (c <= 10);
            irq     = (c >= 3 && c <= 6) ? 32'h0000_0008 : 32'h0;
            mie     = 32'hFFFF_FFF7;
            dbg     = (c == 7);
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL masked c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs, cnt,
                         exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            if (c >= 3 && c <= 7) begin
                checks++;
                if (wfs !== (c == 7) || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL masked_direct c%0d: wake %b busy %b", c, wfs, busy);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_clear();
        do_reset();
        for (int c = 0; c < 13; c++) begin
            wfi_req = (c <= 11);
            clr     = (c == 5);
            dbg     = (c == 8);
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL clear c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs, cnt,
                         exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (cnt !== 32'(c - 6)) begin
                    errors++;
                    $display("FAIL clear_direct c%0d: cnt %0d want %0d", c, cnt, c - 6);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int sc_m = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            sc_inc = 1;
            sc_clr = (c == 10);
            #2;
            checks++;
            if (sc_cnt !== 3'(sc_m)) begin
                errors++;
                $display("FAIL saturation c%0d: cnt %0d want %0d", c, sc_cnt, sc_m);
            end
            tick();
            sc_m = sc_clr ? 0 : (sc_m < 7 ? sc_m + 1 : 7);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_sleep();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            wfi_req = (c <= 4);
            rst     = (c == 5);
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL rst_sleep c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs,
                         cnt, exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            if (c >= 6) begin
                checks++;
                if (busy !== 1'b1 || cnt !== 32'h0 || ack !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_sleep_direct c%0d: busy %b cnt %h ack %b", c, busy, cnt, ack);
                end
            end
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_random();
        logic hold = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            wfi_req = rst ? 1'b0 : (hold || ($urandom_range(0, 3) == 0));
            nop     = ($urandom_range(0, 3) == 0);
            if_b    = ($urandom_range(0, 2) == 0);
            lsu_b   = ($urandom_range(0, 2) == 0);
            apu_b   = ($urandom_range(0, 2) == 0);
            dbg     = ($urandom_range(0, 15) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            irq     = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            mie     = $urandom;
            settle();
            checks++;
            if ({ack, busy, wfs, cnt} !== {exp_ack, exp_busy, exp_wfs, exp_cnt}) begin
                errors++;
                $display("FAIL random c%0d: got %b %b %b %h want %b %b %b %h", c, ack, busy, wfs,
                         cnt, exp_ack, exp_busy, exp_wfs, exp_cnt);
            end
            hold = wfi_req && !exp_ack && !rst;
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        #1;
        test_reset();
        test_nop();
        test_full_sleep();
        test_abort_drain();
        test_masked_irq();
        test_clear();
        test_saturation();
        test_reset_mid_sleep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e41p_wake_ctrl.md
# cv32e41p_wake_ctrl

WFI sleep-entry/wake-up sequencer sitting directly upstream of the core sleep unit. Accepts a WFI request from the controller, drains the fetch, LSU and APU units, then drops `ctrl_busy_o` so the sleep unit can gate the core clock. It watches enabled interrupts and debug requests to raise `wake_from_sleep_o` and, after a programmable settle delay, retires the WFI. Runs on the ungated clock so it can observe wake events while the core clock is off.

## Interface
- `WAKE_DELAY`, default 2: extra WAKE-state cycles before WFI retirement. Legal range 0..15.
- `clk_ungated_i`  in  1  free-running clock
- `rst_i`  in  1  synchronous, active-high reset
- `wfi_req_i`  in  1  controller has a WFI in ID; held high until `wfi_ack_o`
- `debug_wfi_no_sleep_i`  in  1  WFI executes as NOP (debug mode, single-step, trigger)
- `if_busy_i`, `lsu_busy_i`, `apu_busy_i`  in  1 each  unit busy flags
- `irq_i`  in  32  raw interrupt lines
- `mie_i`  in  32  interrupt enable mask
- `debug_req_i`  in  1  external debug request
- `wfi_ack_o`  out  1  single-cycle pulse; WFI retired, controller advances
- `ctrl_busy_o`  out  1  to sleep unit; low only while sleeping
- `wake_from_sleep_o`  out  1  to sleep unit clock enable
- `sleep_cnt_clr_i`  in  1  clear sleep-cycle counter
- `sleep_cnt_o`  out  32  saturating count of cycles spent in SLEEP

## Operation
- `wake_pend` = `|(irq_i & mie_i) | debug_req_i`. It is combinational and independent of the global MIE bit.
- States: RUN, DRAIN, SLEEP, WAKE. Reset state is RUN.
- **RUN**
  - `wfi_req_i && (debug_wfi_no_sleep_i || wake_pend)` → `wfi_ack_o` = 1 this cycle; stay in RUN.
  - `wfi_req_i` with neither condition true → DRAIN.
- **DRAIN**
  - `wake_pend` → WAKE. Abort has priority over the idle check.
  - Otherwise, if `!if_busy_i && !lsu_busy_i && !apu_busy_i` → SLEEP.
  - Otherwise stay in DRAIN.
- **SLEEP**
  - `wake_pend` → WAKE, with `wake_from_sleep_o` = 1 in that same cycle.
  - Otherwise stay in SLEEP.
- **WAKE**
  - Delay counter runs 0..`WAKE_DELAY`.
  - `wfi_ack_o` = 1 when the counter equals `WAKE_DELAY`, then → RUN.
  - The counter clears on entry to WAKE.
- `ctrl_busy_o` = 1 in RUN, DRAIN and WAKE; 0 in SLEEP.
- `wake_from_sleep_o` = SLEEP && `wake_pend`. Combinational, so the gated clock is re-enabled at the next edge.
- Sleep counter:
  - Increments each cycle the state is SLEEP.
  - Saturates at 0xFFFF_FFFF.
  - `sleep_cnt_clr_i` has priority over increment; clear and increment in the same cycle → 0.
- Deasserting `wfi_req_i` before `wfi_ack_o` is a protocol violation. The FSM ignores the deassertion and completes the sequence.

## Timing
- Reset values:
  - state RUN
  - `wfi_ack_o` = 0
  - `ctrl_busy_o` = 1
  - `wake_from_sleep_o` = 0
  - `sleep_cnt_o` = 0
  - wake delay counter = 0
- Reset asserted in any state → RUN at the next edge. The counter is cleared and no ack is produced.
- NOP WFI: ack in the same cycle as `wfi_req_i` (0-cycle latency).
- Minimum sleep path (units idle at request):
  - Cycle 0: RUN, request.
  - Cycle 1: DRAIN.
  - Cycle 2: SLEEP, `ctrl_busy_o` = 0.
- Wake path:
  - `wake_pend` seen in SLEEP at cycle n.
  - WAKE occupies cycles n+1 .. n+1+`WAKE_DELAY`.
  - Ack in cycle n+1+`WAKE_DELAY`.
  - RUN at cycle n+2+`WAKE_DELAY`.
- `wake_pend` and units-idle in the same DRAIN cycle → WAKE; SLEEP is never entered and the counter does not increment.
- `wfi_req_i` is ignored in DRAIN, SLEEP and WAKE.
- A `wake_pend` pulse of a single cycle is sufficient. The FSM does not require it to persist in WAKE.

## Structure
- `cv32e41p_pkg` gains `wake_ctrl_state_e` (WK_RUN, WK_DRAIN, WK_SLEEP, WK_WAKE) and `WAKE_DELAY_W = 4`.
- One sub-module: `cv32e41p_sat_counter`. It is a parameterised-width saturating counter with increment and clear, instantiated for `sleep_cnt_o`.
- The FSM, delay counter and output decode stay in `cv32e41p_wake_ctrl`.

## Test plan
- **NOP WFI:** `debug_wfi_no_sleep_i` = 1, `wfi_req_i` pulse → `wfi_ack_o` = 1 the same cycle, `ctrl_busy_o` stays 1, `sleep_cnt_o` = 0.
- **Full sleep:**
  - Stimulus: `WAKE_DELAY` = 2; `lsu_busy_i` high for 3 cycles after request.
  - Expected: SLEEP at cycle 4 and `ctrl_busy_o` = 0.
  - Stimulus: `irq_i[11]` = 1 with `mie_i[11]` = 1 at cycle 10.
  - Expected: `wake_from_sleep_o` = 1 at cycle 10, ack at cycle 13, `sleep_cnt_o` = 6.
- **Masked irq:** `irq_i[3]` = 1 with `mie_i[3]` = 0 during SLEEP → no wake. A later `debug_req_i` = 1 → wake.
- **Abort in DRAIN:** `debug_req_i` and units-idle in the same DRAIN cycle → WAKE; `ctrl_busy_o` never 0; `sleep_cnt_o` unchanged.
- **Saturation and clear:** preload the counter near 0xFFFF_FFFE and sleep 5 cycles → reads 0xFFFF_FFFF. Clear asserted during SLEEP → 0 that cycle, then increments.
- **Reset mid-sleep:** `rst_i` = 1 in SLEEP → RUN, `ctrl_busy_o` = 1, `sleep_cnt_o` = 0, no `wfi_ack_o`.
